hist_extreme_tracker: RTL
=========================

# hist_extreme_tracker

Multi-lane, frame-based successor to the single-pixel minimum detector in the histogram-equalisation pipeline. It tracks both the minimum and the maximum pixel value over a frame, and counts how often each occurs. The minimum's occurrence count is the cdf_min term for the equalisation LUT; the maximum feeds dynamic-range checks. Results are published once per frame with a one-cycle valid strobe, and a partially received frame can be discarded on abort.

## Interface
- DataWidth, 8: bits per pixel.
- Lanes, 1: pixels per beat (1, 2 or 4); lane 0 occupies the LSBs of i_pixel.
- CountWidth, $clog2(640*480+1): width of the occurrence counters (saturating).

- i_clk  input  1  sole clock; all logic on its rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_pixel  input  DataWidth*Lanes  packed pixel beat.
- i_pixel_valid  input  1  beat qualifier; no backpressure, every valid beat is consumed.
- i_pixel_last  input  1  marks the final beat of a frame; ignored unless i_pixel_valid=1.
- i_frame_abort  input  1  discards the current partial frame.
- o_min_value  output  DataWidth  minimum of the last published frame.
- o_min_count  output  CountWidth  occurrences of o_min_value (cdf_min).
- o_max_value  output  DataWidth  maximum of the last published frame.
- o_max_count  output  CountWidth  occurrences of o_max_value.
- o_stats_valid  output  1  one-cycle strobe when new results are published.

## Operation
- **Stage 1 (beat reduce), on a valid beat:**
  - beat_min = minimum over the lanes; beat_min_n = number of lanes equal to beat_min (1..Lanes).
  - beat_max and beat_max_n are computed the same way.
  - last and valid are registered alongside these values.
- **Stage 2 (accumulate), on a stage-1 valid beat:**
  - If the `empty` flag is set, load run_min/run_min_cnt/run_max/run_max_cnt from the beat values and clear `empty`.
  - Otherwise, for the minimum:
    - beat_min < run_min: load value and count.
    - beat_min == run_min: run_min_cnt = sat(run_min_cnt + beat_min_n).
    - beat_min > run_min: hold.
  - The maximum is handled symmetrically.
- **Publish (stage-1 beat with last=1):**
  - Write the merged result of that beat (not the pre-beat state) to the four outputs.
  - Pulse o_stats_valid and set `empty`.
- **Output hold:** outputs hold their value between publishes.
- **Saturation:** counters saturate at 2**CountWidth-1 and never wrap.
- **Abort (i_frame_abort=1):**
  - Sets `empty` and clears the stage-1 valid register.
  - A beat presented in the same cycle is dropped.
  - Published outputs are unchanged, and no strobe is issued for the aborted frame.
- **Frame with no beats:** a frame is defined by its beats, so nothing is published without a last beat.

## Timing
- **Reset (i_reset_n=0 at an edge):**
  - o_min_value=0, o_min_count=0, o_max_value=0, o_max_count=0, o_stats_valid=0.
  - `empty`=1 and stage-1 valid=0.
  - All other inputs are ignored in that cycle.
- **Latency:** a last beat sampled at edge T produces o_stats_valid=1 and new outputs after edge T+1, held for exactly one cycle (until edge T+2).
- **Back-to-back frames:** a new frame may start on the beat immediately after last with no bubble. The publish at T+1 and the load of the next frame's first beat at T+2 do not interfere.
- **Single-beat frame:** valid=1 and last=1 on the same beat publishes that beat's reduction alone.
- **Abort and stage 2 in the same cycle:** abort cancels any stage-1 beat still pending. If that pending beat carried last, its publish is suppressed.
- **Reset mid-frame:** all accumulation is lost and previously published outputs return to 0.

## Test plan
- **Lanes=1, single frame:** beats 200, 50, 50, 255, 50(last) -> o_stats_valid one cycle, 2 edges after the last beat; min=50/count=3, max=255/count=1.
- **Lanes=4, ties within and across lanes:** beats {10,10,20,30}, {10,40,40,5}(last), lane 0 listed first -> min=5/count=1, max=40/count=2.
- **Lanes=1, back-to-back frames:** frame A = 3, 3(last); frame B = 9(last) on the next cycle -> two strobes on consecutive cycles; A reports min=3/count=2 and max=3/count=2, then B reports 9/1, 9/1.
- **Abort mid-frame:** after a published frame with min=7, send 1, 1, then abort concurrent with a beat of 0, then 4(last) -> only the frame {4} is published: min=4/count=1, max=4/count=1, with no strobe in between.
- **Saturation, CountWidth=3:** ten beats of 7 with last on the tenth -> min=7 and max=7, both counts 7.
- **Reset mid-frame:** reset asserted after 2 beats -> all outputs 0 and no strobe; a following frame 100(last) publishes 100/1, 100/1.

Source files
------------

// File: rtl/hist_extreme_tracker.sv
// Frame-based min/max tracker: reduces each multi-lane beat, accumulates the running
// extremes with saturating occurrence counts, and publishes them once per frame.
module hist_extreme_tracker #(
   parameter int DataWidth  = 8,
   parameter int Lanes      = 1,
   parameter int CountWidth = $clog2(640*480+1)
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic [DataWidth*Lanes-1:0]   i_pixel,
   input  logic                         i_pixel_valid,
   input  logic                         i_pixel_last,
   input  logic                         i_frame_abort,
   output logic [DataWidth-1:0]         o_min_value,
   output logic [CountWidth-1:0]        o_min_count,
   output logic [DataWidth-1:0]         o_max_value,
   output logic [CountWidth-1:0]        o_max_count,
   output logic                         o_stats_valid
);

   localparam int LaneCntW = $clog2(Lanes + 1);
   localparam int SumW     = ((CountWidth > LaneCntW) ? CountWidth : LaneCntW) + 1;
   localparam logic [SumW-1:0] CntMax = {{(SumW-CountWidth){1'b0}}, {CountWidth{1'b1}}};

   logic [DataWidth-1:0]  lane_px [Lanes];
   logic [DataWidth-1:0]  beat_min;
   logic [DataWidth-1:0]  beat_max;
   logic [LaneCntW-1:0]   beat_min_n;
   logic [LaneCntW-1:0]   beat_max_n;

   logic                  s1_valid_reg;
   logic                  s1_last_reg;
   logic [DataWidth-1:0]  s1_min_reg;
   logic [DataWidth-1:0]  s1_max_reg;
   logic [LaneCntW-1:0]   s1_min_n_reg;
   logic [LaneCntW-1:0]   s1_max_n_reg;

   logic                  empty_reg;
   logic [DataWidth-1:0]  run_min_reg;
   logic [DataWidth-1:0]  run_max_reg;
   logic [CountWidth-1:0] run_min_cnt_reg;
   logic [CountWidth-1:0] run_max_cnt_reg;

   logic [DataWidth-1:0]  merge_min;
   logic [DataWidth-1:0]  merge_max;
   logic [CountWidth-1:0] merge_min_cnt;
   logic [CountWidth-1:0] merge_max_cnt;

   logic [DataWidth-1:0]  min_value_reg;
   logic [DataWidth-1:0]  max_value_reg;
   logic [CountWidth-1:0] min_count_reg;
   logic [CountWidth-1:0] max_count_reg;
   logic                  stats_valid_reg;

   function automatic logic [CountWidth-1:0] sat_add(input logic [CountWidth-1:0] a,
                                                     input logic [LaneCntW-1:0]   b);
      logic [SumW-1:0] s;
      s = SumW'(a) + SumW'(b);
      if (s > CntMax) return {CountWidth{1'b1}};
      return s[CountWidth-1:0];
   endfunction

   generate
      for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
         assign lane_px[gi] = i_pixel[gi*DataWidth +: DataWidth];
      end
   endgenerate

   always_comb begin
      beat_min   = lane_px[0];
      beat_max   = lane_px[0];
      beat_min_n = '0;
      beat_max_n = '0;
      for (int l = 1; l < Lanes; l++) begin
         if (lane_px[l] < beat_min) beat_min = lane_px[l];
         if (lane_px[l] > beat_max) beat_max = lane_px[l];
      end
      // Second pass counts ties against the final extremes, not the running ones.
      for (int l = 0; l < Lanes; l++) begin
         if (lane_px[l] == beat_min) beat_min_n = beat_min_n + LaneCntW'(1);
         if (lane_px[l] == beat_max) beat_max_n = beat_max_n + LaneCntW'(1);
      end
   end

   always_comb begin
      merge_min     = run_min_reg;
      merge_min_cnt = run_min_cnt_reg;
      merge_max     = run_max_reg;
      merge_max_cnt = run_max_cnt_reg;
      if (empty_reg) begin
         merge_min     = s1_min_reg;
         merge_min_cnt = sat_add('0, s1_min_n_reg);
         merge_max     = s1_max_reg;
         merge_max_cnt = sat_add('0, s1_max_n_reg);
      end else begin
         if (s1_min_reg < run_min_reg) begin
            merge_min     = s1_min_reg;
            merge_min_cnt = sat_add('0, s1_min_n_reg);
         end else if (s1_min_reg == run_min_reg) begin
            merge_min_cnt = sat_add(run_min_cnt_reg, s1_min_n_reg);
         end
         if (s1_max_reg > run_max_reg) begin
            merge_max     = s1_max_reg;
            merge_max_cnt = sat_add('0, s1_max_n_reg);
         end else if (s1_max_reg == run_max_reg) begin
            merge_max_cnt = sat_add(run_max_cnt_reg, s1_max_n_reg);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         s1_valid_reg    <= 1'b0;
         s1_last_reg     <= 1'b0;
         s1_min_reg      <= '0;
         s1_max_reg      <= '0;
         s1_min_n_reg    <= '0;
         s1_max_n_reg    <= '0;
         empty_reg       <= 1'b1;
         run_min_reg     <= '0;
         run_max_reg     <= '0;
         run_min_cnt_reg <= '0;
         run_max_cnt_reg <= '0;
         min_value_reg   <= '0;
         max_value_reg   <= '0;
         min_count_reg   <= '0;
         max_count_reg   <= '0;
         stats_valid_reg <= 1'b0;
      end else begin
         stats_valid_reg <= 1'b0;
         if (i_frame_abort) begin
            // Drops both the incoming beat and any beat still waiting in stage 1.
            s1_valid_reg <= 1'b0;
            empty_reg    <= 1'b1;
         end else begin
            s1_valid_reg <= i_pixel_valid;
            if (i_pixel_valid) begin
               s1_last_reg  <= i_pixel_last;
               s1_min_reg   <= beat_min;
               s1_max_reg   <= beat_max;
               s1_min_n_reg <= beat_min_n;
               s1_max_n_reg <= beat_max_n;
            end
            if (s1_valid_reg) begin
               if (s1_last_reg) begin
                  min_value_reg   <= merge_min;
                  min_count_reg   <= merge_min_cnt;
                  max_value_reg   <= merge_max;
                  max_count_reg   <= merge_max_cnt;
                  stats_valid_reg <= 1'b1;
                  empty_reg       <= 1'b1;
               end else begin
                  run_min_reg     <= merge_min;
                  run_min_cnt_reg <= merge_min_cnt;
                  run_max_reg     <= merge_max;
                  run_max_cnt_reg <= merge_max_cnt;
                  empty_reg       <= 1'b0;
               end
            end
         end
      end
   end

   assign o_min_value   = min_value_reg;
   assign o_min_count   = min_count_reg;
   assign o_max_value   = max_value_reg;
   assign o_max_count   = max_count_reg;
   assign o_stats_valid = stats_valid_reg;

endmodule
